// File: rtl/puf_eval_ctrl.sv
// Evaluation controller for one shuffle-chain PUF path: applies a challenge,
// launches the race NREP times, and majority-votes the synchronised chain output.
module puf_eval_ctrl #(
  parameter int SEL_W  = 4,
  parameter int SETTLE = 4,
  parameter int NREP   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             chal_valid,
  output logic             chal_ready,
  input  logic [SEL_W-1:0] chal,
  output logic [SEL_W-1:0] shf_sel,
  output logic [1:0]       shf_din,
  input  logic [1:0]       shf_dout,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp,
  output logic [7:0]       resp_conf,
  output logic             resp_stable
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    LAUNCH = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic [7:0] NREP_L      = 8'(NREP);

  state_t           r_state, w_state_next;
  logic [7:0]       r_phase, w_phase_next;
  logic [7:0]       r_rep, w_rep_next;
  logic [7:0]       r_ones, w_ones_next;
  logic [SEL_W-1:0] r_sel, w_sel_next;
  logic [1:0]       r_din, w_din_next;
  logic             r_resp, w_resp_next;
  logic [7:0]       r_conf, w_conf_next;
  logic             r_stable, w_stable_next;
  logic [1:0]       r_sync1, r_sync2;

  // Bit 0 of the synchroniser is kept only for debug probing, never scored.
  logic w_dbg_unused;
  assign w_dbg_unused = r_sync2[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_phase  <= '0;
      r_rep    <= '0;
      r_ones   <= '0;
      r_sel    <= '0;
      r_din    <= 2'b00;
      r_resp   <= 1'b0;
      r_conf   <= '0;
      r_stable <= 1'b0;
      r_sync1  <= 2'b00;
      r_sync2  <= 2'b00;
    end else begin
      r_state  <= w_state_next;
      r_phase  <= w_phase_next;
      r_rep    <= w_rep_next;
      r_ones   <= w_ones_next;
      r_sel    <= w_sel_next;
      r_din    <= w_din_next;
      r_resp   <= w_resp_next;
      r_conf   <= w_conf_next;
      r_stable <= w_stable_next;
      r_sync1  <= shf_dout;
      r_sync2  <= r_sync1;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_phase_next  = r_phase;
    w_rep_next    = r_rep;
    w_ones_next   = r_ones;
    w_sel_next    = r_sel;
    w_resp_next   = r_resp;
    w_conf_next   = r_conf;
    w_stable_next = r_stable;
    case (r_state)
      IDLE: begin
        if (chal_valid) begin
          w_sel_next   = chal;
          w_rep_next   = '0;
          w_ones_next  = '0;
          w_phase_next = '0;
          w_state_next = ARM;
        end
      end
      ARM: begin
        if (r_phase == SETTLE_LAST) begin
          w_phase_next = '0;
          w_state_next = LAUNCH;
        end else begin
          w_phase_next = r_phase + 8'd1;
        end
      end
      LAUNCH: begin
        if (r_phase == SETTLE_LAST) begin
          w_phase_next = '0;
          w_state_next = SAMPLE;
        end else begin
          w_phase_next = r_phase + 8'd1;
        end
      end
      SAMPLE: begin
        w_ones_next = r_ones + {7'd0, r_sync2[1]};
        w_rep_next  = r_rep + 8'd1;
        if (w_rep_next == NREP_L) begin
          // Response fields are frozen here and held through DONE.
          w_resp_next   = ({w_ones_next, 1'b0} > {1'b0, NREP_L});
          w_conf_next   = w_ones_next;
          w_stable_next = (w_ones_next == 8'd0) || (w_ones_next == NREP_L);
          w_state_next  = DONE;
        end else begin
          w_state_next = ARM;
        end
      end
      DONE: begin
        if (resp_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
    // Race inputs are registered from the next state so the edge lines up with LAUNCH.
    w_din_next = (w_state_next == LAUNCH) ? 2'b11 : 2'b00;
  end

  assign chal_ready  = (r_state == IDLE);
  assign resp_valid  = (r_state == DONE);
  assign shf_sel     = r_sel;
  assign shf_din     = r_din;
  assign resp        = r_resp;
  assign resp_conf   = r_conf;
  assign resp_stable = r_stable;

endmodule
